// File: rtl/ex_mem_stage.sv
// EX stage plus EX/MEM pipeline register: operand forwarding, ALU decode/execute, result register.
// Defining EX_MULT_EN adds an iterative shift-add multiplier (ALUOp=10, funct 0x18) that stalls upstream.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    // ID/EX control
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    // ID/EX data
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [5:0]        funct_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    // MEM/WB forwarding source
    input  logic              MEM_WB_RegWrite_i,
    input  logic [ADDR_W-1:0] MEM_WB_wr_addr_i,
    input  logic [DATA_W-1:0] MEM_WB_data_i,
    // EX/MEM register
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              stall_o
);

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluNor,
        AluSlt,
        AluZero,
        AluMul
    } alu_op_e;

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnMult = 6'h18;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    logic              fwd_exmem_ok;
    logic              fwd_memwb_ok;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] wr_addr;

    // A load sitting in EX/MEM has no data yet; the hazard unit stalls instead.
    assign fwd_exmem_ok = RegWrite_o && !MemtoReg_o && (wr_addr_o != '0);
    assign fwd_memwb_ok = MEM_WB_RegWrite_i && (MEM_WB_wr_addr_i != '0);

    always_comb begin
        rs_fwd = rs_i;
        if (fwd_exmem_ok && (wr_addr_o == rs_addr_i)) begin
            rs_fwd = alu_result_o;
        end else if (fwd_memwb_ok && (MEM_WB_wr_addr_i == rs_addr_i)) begin
            rs_fwd = MEM_WB_data_i;
        end
    end

    always_comb begin
        rt_fwd = rt_i;
        if (fwd_exmem_ok && (wr_addr_o == rt_addr_i)) begin
            rt_fwd = alu_result_o;
        end else if (fwd_memwb_ok && (MEM_WB_wr_addr_i == rt_addr_i)) begin
            rt_fwd = MEM_WB_data_i;
        end
    end

    assign op_a    = rs_fwd;
    assign op_b    = ALUSrc_i ? imm_i : rt_fwd;
    assign wr_addr = ALUSrc_i ? rt_addr_i : rd_addr_i;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    alu_op_e alu_op;

    always_comb begin
        alu_op = AluAdd;
        unique case (ALUOp_i)
            2'b00, 2'b11: alu_op = AluAdd;
            2'b01:        alu_op = AluSub;
            2'b10: begin
                unique case (funct_i)
                    FnAdd, FnAddu: alu_op = AluAdd;
                    FnSub, FnSubu: alu_op = AluSub;
                    FnAnd:         alu_op = AluAnd;
                    FnOr:          alu_op = AluOr;
                    FnXor:         alu_op = AluXor;
                    FnNor:         alu_op = AluNor;
                    FnSlt:         alu_op = AluSlt;
`ifdef EX_MULT_EN
                    FnMult:        alu_op = AluMul;
`else
                    FnMult:        alu_op = AluZero;
`endif
                    default:       alu_op = AluZero;
                endcase
            end
            default:      alu_op = AluAdd;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_res;
    logic              slt_bit;

    assign slt_bit = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAdd:  alu_res = op_a + op_b;
            AluSub:  alu_res = op_a - op_b;
            AluAnd:  alu_res = op_a & op_b;
            AluOr:   alu_res = op_a | op_b;
            AluXor:  alu_res = op_a ^ op_b;
            AluNor:  alu_res = ~(op_a | op_b);
            AluSlt:  alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            // Multiply results come from the FSM, not this path.
            AluZero: alu_res = '0;
            AluMul:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
    logic stall;
    logic mul_capture;

`ifdef EX_MULT_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LastStep = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [3:0]        ctl_q, ctl_d;
    logic [ADDR_W-1:0] hold_wr_q, hold_wr_d;
    logic [DATA_W-1:0] hold_rt_q, hold_rt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        ctl_d       = ctl_q;
        hold_wr_d   = hold_wr_q;
        hold_rt_d   = hold_rt_q;
        stall       = 1'b0;
        mul_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (alu_op == AluMul) begin
                    stall     = 1'b1;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    prod_d    = '0;
                    cnt_d     = '0;
                    ctl_d     = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
                    hold_wr_d = wr_addr;
                    hold_rt_d = rt_fwd;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                stall    = 1'b1;
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                mul_capture = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            ctl_q     <= '0;
            hold_wr_q <= '0;
            hold_rt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            ctl_q     <= ctl_d;
            hold_wr_q <= hold_wr_d;
            hold_rt_q <= hold_rt_d;
        end
    end
`else
    assign stall       = 1'b0;
    assign mul_capture = 1'b0;
`endif

    assign stall_o = stall;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    logic [3:0]        ctl_nxt;
    logic [DATA_W-1:0] res_nxt;
    logic [DATA_W-1:0] rt_nxt;
    logic [ADDR_W-1:0] wr_nxt;

    always_comb begin
        ctl_nxt = {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
        res_nxt = alu_res;
        rt_nxt  = rt_fwd;
        wr_nxt  = wr_addr;
        if (stall) begin
            ctl_nxt = '0;
            res_nxt = '0;
            rt_nxt  = '0;
            wr_nxt  = '0;
        end
`ifdef EX_MULT_EN
        else if (mul_capture) begin
            ctl_nxt = ctl_q;
            res_nxt = prod_q;
            rt_nxt  = hold_rt_q;
            wr_nxt  = hold_wr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            MemRead_o    <= 1'b0;
            MemWrite_o   <= 1'b0;
            alu_result_o <= '0;
            rt_data_o    <= '0;
            wr_addr_o    <= '0;
        end else begin
            RegWrite_o   <= ctl_nxt[3];
            MemtoReg_o   <= ctl_nxt[2];
            MemRead_o    <= ctl_nxt[1];
            MemWrite_o   <= ctl_nxt[0];
            alu_result_o <= res_nxt;
            rt_data_o    <= rt_nxt;
            wr_addr_o    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed spec cases plus random instructions vs a reference model.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [1:0]    ALUOp_i;
    logic          ALUSrc_i;
    logic [DW-1:0] rs_i, rt_i, imm_i;
    logic [5:0]    funct_i;
    logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
    logic          MEM_WB_RegWrite_i;
    logic [AW-1:0] MEM_WB_wr_addr_i;
    logic [DW-1:0] MEM_WB_data_i;
    logic          RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
    logic [DW-1:0] alu_result_o, rt_data_o;
    logic [AW-1:0] wr_addr_o;
    logic          stall_o;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .RegWrite_i       (RegWrite_i),
        .MemtoReg_i       (MemtoReg_i),
        .MemRead_i        (MemRead_i),
        .MemWrite_i       (MemWrite_i),
        .ALUOp_i          (ALUOp_i),
        .ALUSrc_i         (ALUSrc_i),
        .rs_i             (rs_i),
        .rt_i             (rt_i),
        .imm_i            (imm_i),
        .funct_i          (funct_i),
        .rs_addr_i        (rs_addr_i),
        .rt_addr_i        (rt_addr_i),
        .rd_addr_i        (rd_addr_i),
        .MEM_WB_RegWrite_i(MEM_WB_RegWrite_i),
        .MEM_WB_wr_addr_i (MEM_WB_wr_addr_i),
        .MEM_WB_data_i    (MEM_WB_data_i),
        .RegWrite_o       (RegWrite_o),
        .MemtoReg_o       (MemtoReg_o),
        .MemRead_o        (MemRead_o),
        .MemWrite_o       (MemWrite_o),
        .alu_result_o     (alu_result_o),
        .rt_data_o        (rt_data_o),
        .wr_addr_o        (wr_addr_o),
        .stall_o          (stall_o)
    );

    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic          mr;
        logic          mw;
        logic [DW-1:0] res;
        logic [DW-1:0] rtd;
        logic [AW-1:0] wr;
    } exmem_t;

    exmem_t q[$];
    exmem_t prev;   // model's idea of what EX/MEM holds right now
    int     checks = 0;
    int     errors = 0;

    // Monitor: every edge the DUT presents a new EX/MEM value.
    exmem_t act, expv;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            expv = q.pop_front();
            act  = {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, alu_result_o, rt_data_o,
                    wr_addr_o};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL exmem t=%0t: got ctl=%b res=%h rt=%h wr=%0d, want ctl=%b res=%h rt=%h wr=%0d",
                         $time, {act.rw, act.m2r, act.mr, act.mw}, act.res, act.rtd, act.wr,
                         {expv.rw, expv.m2r, expv.mr, expv.mw}, expv.res, expv.rtd, expv.wr);
            end
        end
    end

    function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input logic [5:0] f,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h26:        return a ^ b;
            6'h27:        return ~(a | b);
            6'h2A:        return ($signed(a) < $signed(b)) ? 1 : 0;
            default:      return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr, input logic [DW-1:0] idex);
        if (prev.rw && !prev.m2r && prev.wr != 0 && prev.wr == addr) return prev.res;
        if (MEM_WB_RegWrite_i && MEM_WB_wr_addr_i != 0 && MEM_WB_wr_addr_i == addr)
            return MEM_WB_data_i;
        return idex;
    endfunction

    task automatic chk_stall(input logic want, input string name);
        checks++;
        if (stall_o !== want) begin
            errors++;
            $display("FAIL %s t=%0t: stall_o=%b want %b", name, $time, stall_o, want);
        end
    endtask

    task automatic push_exp(input exmem_t e);
        q.push_back(e);
        prev = e;
    endtask

    // Inputs are already set (at a negedge); predict the next EX/MEM value and advance one cycle.
    task automatic step(input logic check_stall);
        exmem_t        e;
        logic [DW-1:0] a, rtf, b;
        a     = fwd(rs_addr_i, rs_i);
        rtf   = fwd(rt_addr_i, rt_i);
        b     = ALUSrc_i ? imm_i : rtf;
        e.rw  = RegWrite_i;
        e.m2r = MemtoReg_i;
        e.mr  = MemRead_i;
        e.mw  = MemWrite_i;
        e.res = alu_ref(ALUOp_i, funct_i, a, b);
        e.rtd = rtf;
        e.wr  = ALUSrc_i ? rt_addr_i : rd_addr_i;
        if (rst) e = '0;
        push_exp(e);
        #1;
        if (check_stall) chk_stall(1'b0, "stall_idle");
        @(negedge clk);
    endtask

    task automatic nop();
        {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i} = '0;
        ALUOp_i = 2'b00; funct_i = '0;
        rs_i = '0; rt_i = '0; imm_i = '0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0;
        MEM_WB_RegWrite_i = 1'b0; MEM_WB_wr_addr_i = '0; MEM_WB_data_i = '0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [AW-1:0] sa, input logic [DW-1:0] sv,
                         input logic [AW-1:0] ta, input logic [DW-1:0] tv,
                         input logic [AW-1:0] da);
        nop();
        RegWrite_i = 1'b1; ALUOp_i = 2'b10; funct_i = f;
        rs_addr_i = sa; rs_i = sv; rt_addr_i = ta; rt_i = tv; rd_addr_i = da;
    endtask

    logic [5:0] fn_tab [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                6'h3F};

    initial begin
        logic [63:0] full;
        exmem_t      e;
        prev = '0;
        rst  = 1'b1;
        nop();
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        rst = 1'b0;

        // add r3 = 5 + 7
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step(1'b1);
        // sub r4 = r3 - r1 (r3 forwarded from EX/MEM, stale ID/EX value 0); MEM/WB also hits r3
        rtype(6'h22, 5'd3, 32'd0, 5'd1, 32'd2, 5'd4);
        MEM_WB_RegWrite_i = 1'b1; MEM_WB_wr_addr_i = 5'd3; MEM_WB_data_i = 32'd99;
        step(1'b1);
        // MEM/WB alone forwards r3 (EX/MEM holds r4)
        rtype(6'h21, 5'd3, 32'd0, 5'd0, 32'd1, 5'd6);
        MEM_WB_RegWrite_i = 1'b1; MEM_WB_wr_addr_i = 5'd3; MEM_WB_data_i = 32'd99;
        step(1'b1);
        // write r0, then read r0 with MEM/WB also targeting r0: no forwarding
        rtype(6'h20, 5'd1, 32'd12, 5'd2, 32'd0, 5'd0);
        step(1'b1);
        rtype(6'h20, 5'd0, 32'd40, 5'd0, 32'd2, 5'd7);
        MEM_WB_RegWrite_i = 1'b1; MEM_WB_wr_addr_i = 5'd0; MEM_WB_data_i = 32'd99;
        step(1'b1);
        // slt signed: -1 < 1
        rtype(6'h2A, 5'd8, 32'hFFFF_FFFF, 5'd9, 32'd1, 5'd10);
        step(1'b1);
        // sw: address rs+imm, store data is forwarded rt (r10 from EX/MEM)
        nop();
        MemWrite_i = 1'b1; ALUSrc_i = 1'b1; imm_i = 32'd8; rs_addr_i = 5'd11; rs_i = 32'h100;
        rt_addr_i = 5'd10; rt_i = 32'hDEAD;
        step(1'b1);
        // load into r12, then a consumer: load in EX/MEM must not forward
        nop();
        RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1; ALUSrc_i = 1'b1;
        rs_addr_i = 5'd1; rs_i = 32'h40; imm_i = 32'h4; rt_addr_i = 5'd12;
        step(1'b1);
        rtype(6'h20, 5'd12, 32'h55, 5'd0, 32'h1, 5'd13);
        step(1'b1);
        // unknown funct
        rtype(6'h3F, 5'd1, 32'h9, 5'd2, 32'h3, 5'd14);
        step(1'b1);
`ifndef EX_MULT_EN
        rtype(6'h18, 5'd1, 32'hFFFF, 5'd2, 32'h10001, 5'd15);
        step(1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
            MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom);
            ALUOp_i = 2'($urandom); ALUSrc_i = 1'($urandom_range(0, 3) == 0);
            funct_i = fn_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) funct_i = 6'($urandom);
`ifdef EX_MULT_EN
            if (funct_i == 6'h18) funct_i = 6'h20;
`endif
            rs_i = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
            rt_i = $urandom; imm_i = $urandom;
            rs_addr_i = 5'($urandom_range(0, 3)); rt_addr_i = 5'($urandom_range(0, 3));
            rd_addr_i = 5'($urandom_range(0, 3));
            MEM_WB_RegWrite_i = 1'($urandom); MEM_WB_wr_addr_i = 5'($urandom_range(0, 3));
            MEM_WB_data_i = $urandom;
            step(1'b1);
        end

`ifdef EX_MULT_EN
        // mult 0xFFFF x 0x10001 into r5: DATA_W+1 stall cycles, then the product
        rtype(6'h18, 5'd0, 32'hFFFF, 5'd0, 32'h10001, 5'd5);
        full = 64'(rs_i) * 64'(rt_i);
        for (int c = 0; c < DW + 1; c++) begin
            push_exp('0);
            #1;
            chk_stall(1'b1, "mult_busy");
            @(negedge clk);
        end
        e = '0;
        e.rw = 1'b1; e.res = full[DW-1:0]; e.rtd = 32'h10001; e.wr = 5'd5;
        push_exp(e);
        #1;
        chk_stall(1'b0, "mult_done");
        @(negedge clk);
        // product forwarded from EX/MEM, wraps to 0
        rtype(6'h20, 5'd5, 32'h0, 5'd0, 32'h1, 5'd6);
        step(1'b1);
        // reset abandons an in-flight multiply
        rtype(6'h18, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd7);
        for (int c = 0; c < 10; c++) begin
            push_exp('0);
            #1;
            chk_stall(1'b1, "mult_busy2");
            @(negedge clk);
        end
        rst = 1'b1;
        nop();
        step(1'b0);
        rst = 1'b0;
        step(1'b1);
        step(1'b1);
`endif

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
